// File: rtl/mmio_strobe_ctrl.sv
// Memory-mapped I/O strobe controller: decodes a CPU request against a 24-bit
// I/O window and drives a 3-to-8 decoder through SETUP / STROBE / HOLD phases.
module mmio_strobe_ctrl #(
  parameter logic [23:0] IO_BASE     = 24'hFFFF_FF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        a2,
  output logic        a1,
  output logic        a0,
  output logic        e1,
  output logic        ne2,
  output logic        ne3,
  output logic        we_q,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEV_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DEV_W-1:0]   dev;
  logic               in_window_c;
  logic               unused_addr_bits;

  assign in_window_c      = (addr[31:8] == IO_BASE);
  // Only addr[6:4] selects a device; the remaining low bits are don't-care.
  assign unused_addr_bits = ^{addr[7], addr[3:0]};

  assign a2 = dev[2];
  assign a1 = dev[1];
  assign a0 = dev[0];

  // Sequencer: every output is a flop updated alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dev   <= '0;
      we_q  <= 1'b0;
      e1    <= 1'b0;
      ne2   <= 1'b1;
      ne3   <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (in_window_c) begin
              dev   <= addr[6:4];
              we_q  <= we;
              busy  <= 1'b1;
              state <= SETUP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          cnt   <= CNT_W'(WAIT_CYCLES);
          e1    <= 1'b1;
          ne2   <= 1'b0;
          ne3   <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            e1    <= 1'b0;
            ne2   <= 1'b1;
            ne3   <= 1'b1;
            done  <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
